// File: rtl/plot_pkg.sv
// Shared types and defaults for the sprite plotting serialiser.
package plot_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} plot_state_e;

  localparam int DEF_SCREEN_W  = 160;
  localparam int DEF_SCREEN_H  = 120;
  localparam int DEF_BG_COLOUR = 0;

  function automatic int pix_count(input int size);
    return size * size;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Serialises sprite move requests into erase-then-draw pixel sweeps for a
// single vga_adapter write port, granting channels round-robin.
module sprite_plot_arbiter
  import plot_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int SIZE        = 4,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BG_COLOUR   = DEF_BG_COLOUR
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_SPRITES-1:0]          req,
  input  logic [NUM_SPRITES-1:0]          hide,
  input  logic [NUM_SPRITES*X_W-1:0]      x_in,
  input  logic [NUM_SPRITES*Y_W-1:0]      y_in,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] colour_in,
  output logic [NUM_SPRITES-1:0]          ack,
  output logic [X_W-1:0]                  x_out,
  output logic [Y_W-1:0]                  y_out,
  output logic [COLOUR_W-1:0]             colour_out,
  output logic                            plot,
  output logic                            busy
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [SW-1:0]       LAST  = SW'(SIZE - 1);
  localparam logic [X_W:0]        X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]        Y_LIM = (Y_W + 1)'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] BG    = COLOUR_W'(BG_COLOUR);

  logic [NUM_SPRITES-1:0][X_W-1:0]      x_arr;
  logic [NUM_SPRITES-1:0][Y_W-1:0]      y_arr;
  logic [NUM_SPRITES-1:0][COLOUR_W-1:0] col_arr;
  assign x_arr   = x_in;
  assign y_arr   = y_in;
  assign col_arr = colour_in;

  plot_state_e                     state_q, state_d;
  logic [IW-1:0]                   g_q, g_d, rr_ptr_q, rr_ptr_d;
  logic [X_W-1:0]                  nx_q, nx_d;
  logic [Y_W-1:0]                  ny_q, ny_d;
  logic [COLOUR_W-1:0]             ncol_q, ncol_d;
  logic                            hide_q, hide_d;
  logic [NUM_SPRITES-1:0]          drawn_q, drawn_d;
  logic [NUM_SPRITES-1:0][X_W-1:0] old_x_q, old_x_d;
  logic [NUM_SPRITES-1:0][Y_W-1:0] old_y_q, old_y_d;
  logic [SW-1:0]                   dx_q, dx_d, dy_q, dy_d;
  logic [NUM_SPRITES-1:0]          ack_q, ack_d;
  logic [X_W-1:0]                  x_out_q, x_out_d;
  logic [Y_W-1:0]                  y_out_q, y_out_d;
  logic [COLOUR_W-1:0]             col_out_q, col_out_d;
  logic                            plot_q, plot_d;

  logic [NUM_SPRITES-1:0] gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   pix_en, last;
  logic [X_W-1:0]         base_x;
  logic [Y_W-1:0]         base_y;
  logic [COLOUR_W-1:0]    pix_col;
  logic [X_W:0]           sum_x;
  logic [Y_W:0]           sum_y;

  rr_arbiter #(.N(NUM_SPRITES)) u_arb (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  // Output registers carry the pixel addressed by the *next* counter value,
  // so the first pixel of a sweep is already on the port the cycle after grant.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    ncol_d   = ncol_q;
    hide_d   = hide_q;
    drawn_d  = drawn_q;
    old_x_d  = old_x_q;
    old_y_d  = old_y_q;
    rr_ptr_d = rr_ptr_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    ack_d    = '0;
    pix_en   = 1'b0;
    base_x   = nx_q;
    base_y   = ny_q;
    pix_col  = ncol_q;
    last     = (dx_q == LAST) && (dy_q == LAST);

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          g_d    = gnt_idx;
          nx_d   = x_arr[gnt_idx];
          ny_d   = y_arr[gnt_idx];
          ncol_d = col_arr[gnt_idx];
          hide_d = |(gnt & hide);
          dx_d   = '0;
          dy_d   = '0;
          if (|(gnt & drawn_q)) begin
            state_d = S_ERASE;
            pix_en  = 1'b1;
            base_x  = old_x_q[gnt_idx];
            base_y  = old_y_q[gnt_idx];
            pix_col = BG;
          end else if (|(gnt & hide)) begin
            state_d = S_DONE;
            ack_d   = gnt;
          end else begin
            state_d = S_DRAW;
            pix_en  = 1'b1;
            base_x  = x_arr[gnt_idx];
            base_y  = y_arr[gnt_idx];
            pix_col = col_arr[gnt_idx];
          end
        end
      end
      S_ERASE: begin
        base_x  = old_x_q[g_q];
        base_y  = old_y_q[g_q];
        pix_col = BG;
        if (!last) begin
          pix_en = 1'b1;
          if (dx_q == LAST) begin
            dx_d = '0;
            dy_d = dy_q + 1'b1;
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end else if (hide_q) begin
          state_d    = S_DONE;
          ack_d[g_q] = 1'b1;
        end else begin
          state_d = S_DRAW;
          dx_d    = '0;
          dy_d    = '0;
          pix_en  = 1'b1;
          base_x  = nx_q;
          base_y  = ny_q;
          pix_col = ncol_q;
        end
      end
      S_DRAW: begin
        if (!last) begin
          pix_en = 1'b1;
          if (dx_q == LAST) begin
            dx_d = '0;
            dy_d = dy_q + 1'b1;
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end else begin
          state_d    = S_DONE;
          ack_d[g_q] = 1'b1;
        end
      end
      S_DONE: begin
        if (hide_q) begin
          drawn_d[g_q] = 1'b0;
        end else begin
          drawn_d[g_q] = 1'b1;
          old_x_d[g_q] = nx_q;
          old_y_d[g_q] = ny_q;
        end
        rr_ptr_d = (g_q == IW'(NUM_SPRITES - 1)) ? '0 : g_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sum_x     = {1'b0, base_x} + (X_W + 1)'(dx_d);
    sum_y     = {1'b0, base_y} + (Y_W + 1)'(dy_d);
    plot_d    = pix_en && (sum_x < X_LIM) && (sum_y < Y_LIM);
    x_out_d   = pix_en ? sum_x[X_W-1:0] : x_out_q;
    y_out_d   = pix_en ? sum_y[Y_W-1:0] : y_out_q;
    col_out_d = pix_en ? pix_col : col_out_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      rr_ptr_q  <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      ncol_q    <= '0;
      hide_q    <= 1'b0;
      drawn_q   <= '0;
      old_x_q   <= '0;
      old_y_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      ack_q     <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      col_out_q <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_ptr_q  <= rr_ptr_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      ncol_q    <= ncol_d;
      hide_q    <= hide_d;
      drawn_q   <= drawn_d;
      old_x_q   <= old_x_d;
      old_y_q   <= old_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      ack_q     <= ack_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      col_out_q <= col_out_d;
      plot_q    <= plot_d;
    end
  end

  assign ack        = ack_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = col_out_q;
  assign plot       = plot_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Bench for sprite_plot_arbiter: directed vector table, round-robin and reset
// sequences, then random requests against a pixel-list reference model.
module tb_sprite_plot_arbiter;
  import plot_pkg::*;

  localparam int NS = 4, XW = 8, YW = 7, CW = 3, SZ = 4;
  localparam int NP = pix_count(SZ);
  localparam int SCR_W = 160, SCR_H = 120, BGC = 0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NS-1:0]     req, hide, ack;
  logic [NS*XW-1:0]  x_in;
  logic [NS*YW-1:0]  y_in;
  logic [NS*CW-1:0]  colour_in;
  logic [XW-1:0]     x_out;
  logic [YW-1:0]     y_out;
  logic [CW-1:0]     colour_out;
  logic              plot, busy;

  always #5 clk = ~clk;

  sprite_plot_arbiter #(
    .NUM_SPRITES(NS), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .SIZE(SZ),
    .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .BG_COLOUR(BGC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .hide(hide),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .ack(ack),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference model: what is on screen per channel, and the arbitration pointer.
  int m_drawn[NS], m_ox[NS], m_oy[NS], m_ptr;
  int q_exp[$], q_got[$];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int enc(input int x, input int y, input int c);
    return x * 65536 + y * 256 + c;
  endfunction

  function automatic void push_square(input int x, input int y, input int c);
    for (int dy = 0; dy < SZ; dy++)
      for (int dx = 0; dx < SZ; dx++)
        if (x + dx < SCR_W && y + dy < SCR_H) q_exp.push_back(enc(x + dx, y + dy, c));
  endfunction

  function automatic void build_exp(input int ch, input int x, input int y, input int col, input int hd);
    q_exp.delete();
    if (m_drawn[ch] != 0) push_square(m_ox[ch], m_oy[ch], BGC);
    if (hd == 0) push_square(x, y, col);
  endfunction

  function automatic int exp_lat(input int ch, input int hd);
    return 2 + ((m_drawn[ch] != 0) ? NP : 0) + ((hd != 0) ? 0 : NP);
  endfunction

  function automatic void model_upd(input int ch, input int x, input int y, input int hd);
    if (hd != 0) m_drawn[ch] = 0;
    else begin m_drawn[ch] = 1; m_ox[ch] = x; m_oy[ch] = y; end
    m_ptr = (ch + 1) % NS;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin m_drawn[i] = 0; m_ox[i] = 0; m_oy[i] = 0; end
    m_ptr = 0;
  endfunction

  task automatic cmp_pix(input string nm);
    int bad;
    bad = -1;
    chk({nm, "_count"}, q_got.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
      if (bad < 0 && q_got[i] != q_exp[i]) bad = i;
    chk({nm, "_first_bad_idx"}, bad, -1);
  endtask

  task automatic set_ch(input int ch, input int x, input int y, input int col, input int hd);
    x_in[ch*XW +: XW]      = XW'(x);
    y_in[ch*YW +: YW]      = YW'(y);
    colour_in[ch*CW +: CW] = CW'(col);
    hide[ch]               = hd[0];
  endtask

  // Single request from idle; inputs are scrambled right after the grant.
  task automatic do_req(input int ch, input int x, input int y, input int col, input int hd,
                        output int lat, output int np, output int lastpx);
    int el;
    bit got;
    logic [NS-1:0] av;
    build_exp(ch, x, y, col, hd);
    el = exp_lat(ch, hd);
    q_got.delete();
    @(negedge clk);
    chk("ack_low_before_req", ack, 0);
    set_ch(ch, x, y, col, hd);
    req[ch] = 1'b1;
    lat = 1; got = 0; av = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) set_ch(ch, $urandom_range(255), $urandom_range(127), $urandom_range(7), $urandom_range(1));
      if (plot) q_got.push_back(enc(x_out, y_out, colour_out));
      if (ack != 0) begin got = 1; av = ack; end
    end
    req[ch] = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_channel", av, 1 << ch);
    chk("latency", lat, el);
    cmp_pix("pixels");
    model_upd(ch, x, y, hd);
    np = q_got.size();
    lastpx = (q_got.size() > 0) ? q_got[$] : -1;
  endtask

  typedef struct {
    int ch, x, y, col, hd;
    int lat, np, last;
  } vec_t;
  vec_t tv[8];

  initial begin
    int lat, np, lastpx, cnt;
    bit got;
    logic [NS-1:0] av;

    reset_n = 1'b0; req = '0; hide = '0; x_in = '0; y_in = '0; colour_in = '0;
    model_reset();
    #12;
    chk("rst_ack", ack, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_colour_out", colour_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

    tv[0] = '{0,  10,  20, 4, 0, 18, 16, enc(13, 23, 4)};
    tv[1] = '{0,  11,  20, 4, 0, 34, 32, enc(14, 23, 4)};
    tv[2] = '{1, 158, 118, 2, 0, 18,  4, enc(159, 119, 2)};
    tv[3] = '{2,  50,  50, 1, 0, 18, 16, enc(53, 53, 1)};
    tv[4] = '{2,   0,   0, 0, 1, 18, 16, enc(53, 53, 0)};
    tv[5] = '{2,   0,   0, 0, 1,  2,  0, -1};
    tv[6] = '{1,   0,   0, 7, 0, 34, 20, enc(3, 3, 7)};
    tv[7] = '{3,   5,   5, 5, 1,  2,  0, -1};
    for (int i = 0; i < 8; i++) begin
      do_req(tv[i].ch, tv[i].x, tv[i].y, tv[i].col, tv[i].hd, lat, np, lastpx);
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d_plots", i), np, tv[i].np);
      if (tv[i].last >= 0) chk($sformatf("vec%0d_last_px", i), lastpx, tv[i].last);
    end

    // All channels held: grants rotate 0..3 twice with one idle cycle between.
    for (int c = 0; c < NS; c++) set_ch(c, 30 + 20 * c, 60, c + 1, 0);
    @(negedge clk);
    req = '1;
    cnt = 1;
    for (int k = 0; k < 2 * NS; k++) begin
      build_exp(k % NS, 30 + 20 * (k % NS), 60, (k % NS) + 1, 0);
      lat = exp_lat(k % NS, 0);
      q_got.delete();
      got = 0; av = '0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        cnt++;
        if (k > 0 && i == 0) chk("rr_idle_gap_busy", busy, 0);
        if (plot) q_got.push_back(enc(x_out, y_out, colour_out));
        if (ack != 0) begin got = 1; av = ack; end
      end
      if (k == 2 * NS - 1) req = '0;
      chk("rr_ack_seen", got, 1);
      chk($sformatf("rr_grant%0d", k), av, 1 << (k % NS));
      chk("rr_cycles", cnt, lat);
      cmp_pix("rr_pixels");
      model_upd(k % NS, 30 + 20 * (k % NS), 60, 0);
      cnt = 0;
    end

    // Reset in the middle of the draw sweep of a drawn channel.
    @(negedge clk);
    set_ch(3, 20, 20, 5, 0);
    req[3] = 1'b1;
    repeat (24) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("mid_reset_plot", plot, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_ack", ack, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    do_req(3, 20, 20, 5, 0, lat, np, lastpx);
    chk("post_reset_no_erase_latency", lat, NP + 2);
    chk("post_reset_plots", np, NP);

    for (int i = 0; i < 30; i++)
      do_req($urandom_range(NS - 1), $urandom_range(255), $urandom_range(127),
             $urandom_range(7), ($urandom_range(3) == 0) ? 1 : 0, lat, np, lastpx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
